cpu_alu: RTL and testbench
==========================

Name: cpu_alu

Overview:
- RV32I integer ALU for the cpu execute stage.
- Combinational 32-bit result from an opcode and two operands, plus comparison flags for branch resolution.
- A registered copy of result and flags feeds the next pipeline stage.
- Opcode type `t_alu_op` comes from `cpu_pkg`.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the shift amount is log2(XLEN)=5 bits.

Ports:
- clk  input  1  clock; rising edge samples the registered outputs.
- rst  input  1  asynchronous, active-high reset.
- alu_op  input  t_alu_op (4)  operation select.
- alu_in1  input  32  operand A (rs1/pc).
- alu_in2  input  32  operand B (rs2/imm).
- alu_en  input  1  load enable for the registered outputs.
- alu_out  output  32  combinational result.
- alu_zero  output  1  combinational; 1 when alu_out == 0.
- alu_lt  output  1  combinational; signed alu_in1 < alu_in2.
- alu_ltu  output  1  combinational; unsigned alu_in1 < alu_in2.
- alu_out_q  output  32  registered alu_out.
- alu_zero_q  output  1  registered alu_zero.

Behaviour:
- alu_out is purely combinational from alu_op/alu_in1/alu_in2, with zero cycles of latency. It is independent of clk and rst and valid within the same delta.
- Operations (A=alu_in1, B=alu_in2, sh=B[4:0]):
  - ALU_ADD: A+B, mod 2^32, carry discarded.
  - ALU_SUB: A-B, mod 2^32, borrow discarded.
  - ALU_SLT: {31'b0, signed(A)<signed(B)}.
  - ALU_SLTU: {31'b0, A<B unsigned}.
  - ALU_SLL: A<<sh.
  - ALU_SRL: A>>sh, zero fill.
  - ALU_SRA: A>>>sh, sign fill from A[31].
  - ALU_XOR / ALU_OR / ALU_AND: bitwise.
- Shift amount uses B[4:0] only; B[31:5] is ignored (e.g. B=35 shifts by 3). A shift by 0 returns A unchanged.
- Any alu_op encoding not listed above drives alu_out=0. The block has no X-propagation beyond the inputs.
- alu_lt and alu_ltu are computed for every opcode, not only SLT/SLTU.
- Overflow: none flagged. For example, 0x7FFFFFFF+1 = 0x80000000 and 0x80000000-1 = 0x7FFFFFFF.
- Registered path:
  - On rst=1, immediately (asynchronously): alu_out_q=0, alu_zero_q=1.
  - On a rising clk with rst=0 and alu_en=1: alu_out_q<=alu_out, alu_zero_q<=alu_zero.
  - With alu_en=0 the registered outputs hold.
  - Latency is 1 cycle.
- Reset asserted mid-operation clears the registers at once. The combinational outputs are unaffected by rst.
- Reset deassertion is synchronised externally; no internal synchroniser.

Decomposition:
- `cpu_pkg` holds:
  - `typedef enum logic [3:0] t_alu_op` with ALU_ADD=0, ALU_SUB=1, ALU_SLL=2, ALU_SLT=3, ALU_SLTU=4, ALU_XOR=5, ALU_SRL=6, ALU_SRA=7, ALU_OR=8, ALU_AND=9.
  - XLEN=32.
- One sub-module, `alu_shifter`, is natural. It takes A, sh[4:0] and mode (SLL/SRL/SRA) and returns the shifted value. The adder/subtractor and compare logic stay in cpu_alu, with the comparison derived from the subtract result.

Test Plan:
- Arithmetic and overflow:
  - ADD 10+5 -> 15.
  - SUB 10-5 -> 5.
  - ADD 0x7FFFFFFF+1 -> 0x80000000.
  - SUB 0-1 -> 0xFFFFFFFF with alu_zero=0.
  - SUB 7-7 -> 0 with alu_zero=1.
- Compares:
  - SLT A=0xFFFFFFFF (-1), B=1 -> 1.
  - SLTU A=0xFFFFFFFF, B=1 -> 0.
  - SLT 1,-1 -> 0.
  - SLTU 1,0xFFFFFFFF -> 1.
  - For each case, check alu_lt and alu_ltu match.
- Shifts:
  - SLL 1<<3 -> 8.
  - SRL 8>>3 -> 1.
  - SRA -8>>>2 -> 0xFFFFFFFE (-2).
  - SRL 0x80000000>>31 -> 1.
  - SLL with B=35 -> same as shift 3.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
- Logic ops:
  - XOR 0xF0F0F0F0^0x0F0F0F0F -> 0xFFFFFFFF.
  - OR 0xF0F00000|0x0000F0F0 -> 0xF0F0F0F0.
  - AND 0xFF00FF00&0x0F0F0F0F -> 0x0F000F00.
  - Opcode 15 -> 0.
- Registered path:
  - rst=1 -> alu_out_q=0, alu_zero_q=1 with no clk edge.
  - Release rst, ADD 10+5 with alu_en=1, one clk -> alu_out_q=15, alu_zero_q=0.
  - alu_en=0 and change inputs, clk -> alu_out_q holds 15.
  - Assert rst between edges -> alu_out_q=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu execute stage.
//   t_alu_op     : ALU operation select (4-bit encoding used by decode).
//   t_shift_mode : direction/fill selector for the barrel shifter.
//   XLEN         : integer register width.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } t_alu_op;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } t_shift_mode;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for the integer ALU.
// Ports:
//   a_i     : value to shift
//   sh_i    : shift amount (log2(XLEN) bits)
//   mode_i  : SH_SLL, SH_SRL (zero fill) or SH_SRA (sign fill from a_i MSB)
//   shift_o : shifted value
module alu_shifter
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [SHW-1:0]  sh_i,
  input  t_shift_mode     mode_i,
  output logic [XLEN-1:0] shift_o
);

  logic signed [XLEN-1:0] a_s;

  assign a_s = $signed(a_i);

  always_comb begin
    shift_o = '0;
    case (mode_i)
      SH_SLL:  shift_o = a_i << sh_i;
      SH_SRL:  shift_o = a_i >> sh_i;
      SH_SRA:  shift_o = $unsigned(a_s >>> sh_i);
      default: shift_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_alu.sv
// RV32I integer ALU for the execute stage.
// Combinational result and branch-compare flags, plus a registered copy of
// the result and zero flag for the next pipeline stage.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   alu_op                : operation select (t_alu_op)
//   alu_in1, alu_in2      : operands A (rs1/pc) and B (rs2/imm)
//   alu_en                : load enable for the registered outputs
//   alu_out, alu_zero     : combinational result and result==0 flag
//   alu_lt, alu_ltu       : signed / unsigned A<B, valid for every opcode
//   alu_out_q, alu_zero_q : registered result and zero flag (1-cycle latency)
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  t_alu_op         alu_op,
  input  logic [XLEN-1:0] alu_in1,
  input  logic [XLEN-1:0] alu_in2,
  input  logic            alu_en,
  output logic [XLEN-1:0] alu_out,
  output logic            alu_zero,
  output logic            alu_lt,
  output logic            alu_ltu,
  output logic [XLEN-1:0] alu_out_q,
  output logic            alu_zero_q
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN:0]   diff;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] shift_res;
  t_shift_mode     sh_mode;
  logic [XLEN-1:0] out_d;
  logic            zero_d;
  logic [XLEN-1:0] out_q;
  logic            zero_q;

  // One extended subtraction serves SUB and both compares: the extra MSB is
  // the unsigned borrow. For signed compare, differing operand signs decide
  // directly (A negative => A<B); equal signs cannot overflow, so the
  // difference sign bit is the answer.
  assign diff    = {1'b0, alu_in1} - {1'b0, alu_in2};
  assign sum     = alu_in1 + alu_in2;
  assign alu_ltu = diff[XLEN];
  assign alu_lt  = (alu_in1[XLEN-1] != alu_in2[XLEN-1]) ? alu_in1[XLEN-1]
                                                        : diff[XLEN-1];

  always_comb begin
    sh_mode = SH_SLL;
    case (alu_op)
      ALU_SRL: sh_mode = SH_SRL;
      ALU_SRA: sh_mode = SH_SRA;
      default: sh_mode = SH_SLL;
    endcase
  end

  // Only B[4:0] is the shift amount; upper bits of B are ignored.
  alu_shifter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shifter (
    .a_i     (alu_in1),
    .sh_i    (alu_in2[SHW-1:0]),
    .mode_i  (sh_mode),
    .shift_o (shift_res)
  );

  always_comb begin
    out_d = '0;
    case (alu_op)
      ALU_ADD:  out_d = sum;
      ALU_SUB:  out_d = diff[XLEN-1:0];
      ALU_SLT:  out_d = {{(XLEN-1){1'b0}}, alu_lt};
      ALU_SLTU: out_d = {{(XLEN-1){1'b0}}, alu_ltu};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  out_d = shift_res;
      ALU_XOR:  out_d = alu_in1 ^ alu_in2;
      ALU_OR:   out_d = alu_in1 | alu_in2;
      ALU_AND:  out_d = alu_in1 & alu_in2;
      default:  out_d = '0;
    endcase
  end

  assign zero_d   = (out_d == '0);
  assign alu_out  = out_d;
  assign alu_zero = zero_d;

  // Registered stage: cleared result reads as zero, so the zero flag resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      zero_q <= 1'b1;
    end else if (alu_en) begin
      out_q  <= out_d;
      zero_q <= zero_d;
    end
  end

  assign alu_out_q  = out_q;
  assign alu_zero_q = zero_q;

endmodule

// File: tb/tb_cpu_alu.sv
// Self-checking bench for cpu_alu: scoreboard of expected results pushed on
// drive and popped when the DUT output is sampled.
module tb_cpu_alu;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  op_r;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        en;
  logic [31:0] out;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic [31:0] out_q;
  logic        zero_q;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        lt;
    logic        ltu;
  } exp_t;

  exp_t sb[$];
  exp_t sb_reg[$];

  int n_checks = 0;
  int n_errors = 0;

  cpu_alu dut (
    .clk        (clk),
    .rst        (rst),
    .alu_op     (t_alu_op'(op_r)),
    .alu_in1    (in1),
    .alu_in2    (in2),
    .alu_en     (en),
    .alu_out    (out),
    .alu_zero   (zero),
    .alu_lt     (lt),
    .alu_ltu    (ltu),
    .alu_out_q  (out_q),
    .alu_zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written from the instruction-set definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] as;
    logic signed [31:0] bs;
    as = $signed(a);
    bs = $signed(b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return (as < bs) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned(as >>> b[4:0]);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one combinational vector with a hand-computed expected result.
  task automatic comb_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
    exp_t e;
    exp_t g;
    op_r = op;
    in1  = a;
    in2  = b;
    e.res  = exp_res;
    e.zero = (exp_res == 32'd0);
    e.lt   = ($signed(a) < $signed(b));
    e.ltu  = (a < b);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    check({tag, "_out"},  out,           g.res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, g.zero});
    check({tag, "_lt"},   {31'd0, lt},   {31'd0, g.lt});
    check({tag, "_ltu"},  {31'd0, ltu},  {31'd0, g.ltu});
  endtask

  task automatic reg_check(input string tag);
    exp_t g;
    if (sb_reg.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got empty scoreboard expected an entry", tag);
    end else begin
      g = sb_reg.pop_front();
      check({tag, "_q"},    out_q,           g.res);
      check({tag, "_zq"},   {31'd0, zero_q}, {31'd0, g.zero});
    end
  endtask

  task automatic push_reg(input logic [31:0] r, input logic z);
    exp_t e;
    e.res  = r;
    e.zero = z;
    e.lt   = 1'b0;
    e.ltu  = 1'b0;
    sb_reg.push_back(e);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst  = 1'b0;
    en   = 1'b0;
    op_r = 4'd0;
    in1  = '0;
    in2  = '0;

    // Asynchronous reset with no clock edge (first posedge is at t=5).
    #1 rst = 1'b1;
    push_reg(32'd0, 1'b1);
    #1 reg_check("rst_async");

    // Arithmetic and overflow
    comb_vec("add",     4'd0, 32'd10,        32'd5, 32'd15);
    comb_vec("sub",     4'd1, 32'd10,        32'd5, 32'd5);
    comb_vec("add_ovf", 4'd0, 32'h7FFFFFFF,  32'd1, 32'h80000000);
    comb_vec("sub_neg", 4'd1, 32'd0,         32'd1, 32'hFFFFFFFF);
    comb_vec("sub_ovf", 4'd1, 32'h80000000,  32'd1, 32'h7FFFFFFF);
    comb_vec("sub_eq",  4'd1, 32'd7,         32'd7, 32'd0);
    // Compares
    comb_vec("slt_m1",  4'd3, 32'hFFFFFFFF,  32'd1, 32'd1);
    comb_vec("sltu_m1", 4'd4, 32'hFFFFFFFF,  32'd1, 32'd0);
    comb_vec("slt_1",   4'd3, 32'd1, 32'hFFFFFFFF,  32'd0);
    comb_vec("sltu_1",  4'd4, 32'd1, 32'hFFFFFFFF,  32'd1);
    comb_vec("slt_eq",  4'd3, 32'h80000000, 32'h80000000, 32'd0);
    // Shifts
    comb_vec("sll",     4'd2, 32'd1,         32'd3,  32'd8);
    comb_vec("srl",     4'd6, 32'd8,         32'd3,  32'd1);
    comb_vec("sra",     4'd7, 32'hFFFFFFF8,  32'd2,  32'hFFFFFFFE);
    comb_vec("srl31",   4'd6, 32'h80000000,  32'd31, 32'd1);
    comb_vec("sll35",   4'd2, 32'd1,         32'd35, 32'd8);
    comb_vec("sra31",   4'd7, 32'h80000000,  32'd31, 32'hFFFFFFFF);
    comb_vec("sll0",    4'd2, 32'hA5A5A5A5,  32'hFFFFFFE0, 32'hA5A5A5A5);
    comb_vec("sra_pos", 4'd7, 32'h40000000,  32'd4,  32'h04000000);
    // Logic ops and illegal opcodes
    comb_vec("xor",     4'd5, 32'hF0F0F0F0,  32'h0F0F0F0F, 32'hFFFFFFFF);
    comb_vec("or",      4'd8, 32'hF0F00000,  32'h0000F0F0, 32'hF0F0F0F0);
    comb_vec("and",     4'd9, 32'hFF00FF00,  32'h0F0F0F0F, 32'h0F000F00);
    comb_vec("op15",    4'd15, 32'h12345678, 32'h9ABCDEF0, 32'd0);
    comb_vec("op10",    4'd10, 32'h12345678, 32'h9ABCDEF0, 32'd0);

    // Random vectors against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? ra : $urandom;
      comb_vec("rand", rop, ra, rb, model(rop, ra, rb));
    end

    // Registered path
    @(negedge clk);
    rst = 1'b0;
    op_r = 4'd0; in1 = 32'd10; in2 = 32'd5; en = 1'b1;
    push_reg(32'd15, 1'b0);
    @(posedge clk); #1 reg_check("reg_add");

    @(negedge clk);
    en = 1'b0; op_r = 4'd1; in1 = 32'd7; in2 = 32'd7;
    push_reg(32'd15, 1'b0);
    @(posedge clk); #1 reg_check("reg_hold");

    @(negedge clk);
    en = 1'b1;
    push_reg(32'd0, 1'b1);
    @(posedge clk); #1 reg_check("reg_zero");

    @(negedge clk);
    op_r = 4'd0; in1 = 32'd10; in2 = 32'd5;
    push_reg(32'd15, 1'b0);
    @(posedge clk); #1 reg_check("reg_add2");

    // Reset between edges clears at once; combinational path unaffected.
    @(negedge clk);
    #1 rst = 1'b1;
    push_reg(32'd0, 1'b1);
    #1 reg_check("reg_rst_mid");
    check("rst_comb", out, 32'd15);

    @(posedge clk); #1;
    push_reg(32'd0, 1'b1);
    reg_check("reg_rst_hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
